// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: default widths, ALU op codes and FSM states.
package alu_pkg;

  localparam int ALU_OP_WIDTH   = 4;
  localparam int ALU_DATA_WIDTH = 32;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL  = 4'd2;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLT  = 4'd3;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU = 4'd4;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR  = 4'd5;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL  = 4'd6;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA  = 4'd7;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OR   = 4'd8;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_AND  = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/alu_arb_pick.sv
// Combinational winner select between the two ALU requesters.
// ALU_ARB_RR_EN selects round-robin on last_grant; otherwise port 0 has fixed priority.
module alu_arb_pick (
  input  logic       valid0,
  input  logic       valid1,
`ifdef ALU_ARB_RR_EN
  input  logic       last_grant,
`endif
  output logic [1:0] grant
);

`ifdef ALU_ARB_RR_EN
  // On a tie the port that did not win last time goes next.
  always_comb begin
    grant[0] = valid0 && (!valid1 || last_grant);
    grant[1] = valid1 && (!valid0 || !last_grant);
  end
`else
  always_comb begin
    grant[0] = valid0;
    grant[1] = valid1 && !valid0;
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Two-port arbiter sharing one single-cycle ALU: accept -> execute -> respond.
// Arbitration policy selected by ALU_ARB_RR_EN (round-robin when defined, port 0 priority otherwise).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int OP_WIDTH   = ALU_OP_WIDTH,
  parameter int DATA_WIDTH = ALU_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [OP_WIDTH-1:0]   req0_op,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [DATA_WIDTH-1:0] rsp0_result,
  output logic                  rsp0_zero,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [OP_WIDTH-1:0]   req1_op,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp1_result,
  output logic                  rsp1_zero,
  output logic [OP_WIDTH-1:0]   alu_ctrl,
  output logic [DATA_WIDTH-1:0] alu_src_a,
  output logic [DATA_WIDTH-1:0] alu_src_b,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_zero,
  output logic                  busy
);

  arb_state_t            state;
  logic                  owner;
  logic [1:0]            grant;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  zero_q;

`ifdef ALU_ARB_RR_EN
  logic last_grant;

  alu_arb_pick u_pick (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (state == IDLE && grant != 2'b00) begin
      last_grant <= grant[1];
    end
  end
`else
  alu_arb_pick u_pick (
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .grant  (grant)
  );
`endif

  // Ready is gated by rst_n so nothing looks accepted while reset is held.
  always_comb begin
    req0_ready  = rst_n && (state == IDLE) && grant[0];
    req1_ready  = rst_n && (state == IDLE) && grant[1];
    rsp0_valid  = (state == RESP) && !owner;
    rsp1_valid  = (state == RESP) && owner;
    rsp0_result = rsp0_valid ? result_q : '0;
    rsp0_zero   = rsp0_valid && zero_q;
    rsp1_result = rsp1_valid ? result_q : '0;
    rsp1_zero   = rsp1_valid && zero_q;
    busy        = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= 1'b0;
      alu_ctrl  <= OP_WIDTH'(ALU_ADD);
      alu_src_a <= '0;
      alu_src_b <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant != 2'b00) begin
            owner     <= grant[1];
            alu_ctrl  <= grant[1] ? req1_op : req0_op;
            alu_src_a <= grant[1] ? req1_a  : req0_a;
            alu_src_b <= grant[1] ? req1_b  : req0_b;
            state     <= EXEC;
          end
        end
        EXEC: begin
          result_q <= alu_result;
          zero_q   <= alu_zero;
          state    <= RESP;
        end
        RESP: begin
          if (owner ? rsp1_ready : rsp0_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table, arbitration sequence and mid-op reset.
module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 0, req1_valid = 0, rsp0_ready = 1, rsp1_ready = 1;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_zero, rsp1_zero;
  logic [3:0]  req0_op = 0, req1_op = 0, alu_ctrl;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [31:0] rsp0_result, rsp1_result, alu_src_a, alu_src_b, alu_result;
  logic        alu_zero, busy;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          port;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_r;
    logic        exp_z;
    int          hold;
  } vec_t;

  typedef struct {
    int          port;
    logic [31:0] r;
    logic        z;
  } sb_t;

  sb_t  sb[$];
  vec_t tbl[11];

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
    .alu_ctrl(alu_ctrl), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
  );

  // Stand-in ALU; undefined codes return a+b+0x100 so pass-through is visible.
  always_comb begin
    case (alu_ctrl)
      4'd0: alu_result = alu_src_a + alu_src_b;
      4'd1: alu_result = alu_src_a - alu_src_b;
      4'd2: alu_result = alu_src_a << alu_src_b[4:0];
      4'd3: alu_result = ($signed(alu_src_a) < $signed(alu_src_b)) ? 32'd1 : 32'd0;
      4'd4: alu_result = (alu_src_a < alu_src_b) ? 32'd1 : 32'd0;
      4'd5: alu_result = alu_src_a ^ alu_src_b;
      4'd6: alu_result = alu_src_a >> alu_src_b[4:0];
      4'd7: alu_result = $unsigned($signed(alu_src_a) >>> alu_src_b[4:0]);
      4'd8: alu_result = alu_src_a | alu_src_b;
      4'd9: alu_result = alu_src_a & alu_src_b;
      default: alu_result = alu_src_a + alu_src_b + 32'h100;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic get_ready(input int p);
    return (p != 0) ? req1_ready : req0_ready;
  endfunction

  function automatic logic get_rsp_valid(input int p);
    return (p != 0) ? rsp1_valid : rsp0_valid;
  endfunction

  function automatic logic [31:0] get_result(input int p);
    return (p != 0) ? rsp1_result : rsp0_result;
  endfunction

  function automatic logic get_zero(input int p);
    return (p != 0) ? rsp1_zero : rsp0_zero;
  endfunction

  task automatic drive(input int p, input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (p == 0) begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_req0_ready"}, req0_ready, 0);
    chk({tag, "_req1_ready"}, req1_ready, 0);
    chk({tag, "_rsp0_valid"}, rsp0_valid, 0);
    chk({tag, "_rsp1_valid"}, rsp1_valid, 0);
    chk({tag, "_rsp0_result"}, rsp0_result, 0);
    chk({tag, "_rsp1_result"}, rsp1_result, 0);
    chk({tag, "_alu_ctrl"}, alu_ctrl, 0);
    chk({tag, "_alu_src_a"}, alu_src_a, 0);
    chk({tag, "_alu_src_b"}, alu_src_b, 0);
  endtask

  task automatic do_op(input vec_t v);
    int n;
    sb_t e;
    logic [31:0] held;
    if (v.port == 0) rsp0_ready = (v.hold == 0); else rsp1_ready = (v.hold == 0);
    @(negedge clk);
    drive(v.port, 1'b1, v.op, v.a, v.b);
    #1;
    n = 0;
    while (!get_ready(v.port) && n < 8) begin
      @(negedge clk); #1; n++;
    end
    chk("accept_wait", n, 0);
    if (n < 8) sb.push_back('{v.port, v.exp_r, v.exp_z});
    @(negedge clk);
    drive(v.port, 1'b0, 4'd0, 32'd0, 32'd0);
    #1;
    chk("exec_alu_ctrl", alu_ctrl, v.op);
    chk("exec_alu_src_a", alu_src_a, v.a);
    chk("exec_alu_src_b", alu_src_b, v.b);
    chk("exec_rsp_valid", get_rsp_valid(v.port), 0);
    @(negedge clk); #1;
    chk("resp_valid", get_rsp_valid(v.port), 1);
    chk("resp_other_valid", get_rsp_valid(1 - v.port), 0);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("resp_result", get_result(e.port), e.r);
      chk("resp_zero", get_zero(e.port), e.z);
    end else begin
      chk("scoreboard_empty", 1, 0);
    end
    held = get_result(v.port);
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk); #1;
      chk("hold_valid", get_rsp_valid(v.port), 1);
      chk("hold_result", get_result(v.port), held);
      chk("hold_zero", get_zero(v.port), v.exp_z);
      chk("hold_other_valid", get_rsp_valid(1 - v.port), 0);
      chk("hold_other_ready", get_ready(1 - v.port), 0);
    end
    if (v.port == 0) rsp0_ready = 1; else rsp1_ready = 1;
    @(negedge clk); #1;
    chk("post_resp_busy", busy, 0);
  endtask

  initial begin
    int k, c;
    int gp[4];
    int acc[4];
    sb_t e;

    tbl[0]  = '{0, 4'd0, 32'd5,          32'd7,  32'd12,         1'b0, 0};
    tbl[1]  = '{0, 4'd2, 32'd1,          32'd4,  32'd16,         1'b0, 0};
    tbl[2]  = '{1, 4'd3, 32'hFFFF_FFFF,  32'd2,  32'd1,          1'b0, 0};
    tbl[3]  = '{0, 4'd4, 32'hFFFF_FFFF,  32'd2,  32'd0,          1'b1, 0};
    tbl[4]  = '{1, 4'd5, 32'hF0,         32'hFF, 32'h0F,         1'b0, 1};
    tbl[5]  = '{0, 4'd6, 32'h8000_0000,  32'd4,  32'h0800_0000,  1'b0, 0};
    tbl[6]  = '{1, 4'd7, 32'h8000_0000,  32'd4,  32'hF800_0000,  1'b0, 0};
    tbl[7]  = '{0, 4'd8, 32'hA,          32'h5,  32'hF,          1'b0, 2};
    tbl[8]  = '{1, 4'd9, 32'hC,          32'hA,  32'h8,          1'b0, 0};
    tbl[9]  = '{0, 4'hF, 32'd1,          32'd2,  32'h103,        1'b0, 0};
    tbl[10] = '{1, 4'd1, 32'd9,          32'd9,  32'd0,          1'b1, 4};

    #2;
    check_idle_outputs("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) do_op(tbl[i]);

    // Both ports valid continuously; record who wins and when.
    @(negedge clk);
    drive(0, 1'b1, 4'd0, 32'd1, 32'd1);
    drive(1, 1'b1, 4'd5, 32'd3, 32'd3);
    k = 0; c = 0;
    while ((k < 4 || sb.size() > 0) && c < 40) begin
      #1;
      if (rsp0_valid || rsp1_valid) begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("arb_rsp_port", rsp1_valid, e.port);
          chk("arb_rsp_result", rsp1_valid ? rsp1_result : rsp0_result, e.r);
          chk("arb_rsp_zero", rsp1_valid ? rsp1_zero : rsp0_zero, e.z);
        end else begin
          chk("arb_unexpected_rsp", 1, 0);
        end
      end
      if (k < 4 && (req0_ready || req1_ready)) begin
        chk("arb_single_grant", req0_ready & req1_ready, 0);
        gp[k] = req1_ready ? 1 : 0;
        acc[k] = c;
        if (req1_ready) sb.push_back('{1, 32'd0, 1'b1});
        else            sb.push_back('{0, 32'd2, 1'b0});
        k++;
        if (k == 4) begin
          @(posedge clk); #1;
          req0_valid = 0; req1_valid = 0;
        end
      end
      @(negedge clk);
      c++;
    end
    chk("arb_accept_count", k, 4);
    for (int i = 0; i < k; i++) begin
`ifdef ALU_ARB_RR_EN
      chk("arb_grant_rr", gp[i], i % 2);
`else
      chk("arb_grant_fixed", gp[i], 0);
`endif
      if (i > 0) chk("arb_spacing", acc[i] - acc[i-1], 3);
    end

    // Reset while the op is in EXEC: everything drops and the op never answers.
    @(negedge clk);
    drive(0, 1'b1, 4'd0, 32'd2, 32'd3);
    #1;
    chk("rst_accept", req0_ready, 1);
    @(negedge clk);
    drive(0, 1'b0, 4'd0, 32'd0, 32'd0);
    req1_valid = 1;
    #1;
    chk("rst_exec_busy", busy, 1);
    chk("rst_exec_src_a", alu_src_a, 2);
    rst_n = 0;
    #1;
    check_idle_outputs("rst_mid");
    req1_valid = 0;
    sb.delete();
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      chk("rst_no_rsp0", rsp0_valid, 0);
      chk("rst_no_rsp1", rsp1_valid, 0);
      chk("rst_no_busy", busy, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
